present_drop_scheduler: RTL and testbench
=========================================

Name: present_drop_scheduler

Overview:
- Sequences the three on-screen present slots: decides when a popped ball drops a present, allocates a free slot, picks the present type, and tracks each slot's lifetime.
- Drives per-slot visible/reset lines into the present objects and the present controller.
- Reports collected presents to the game logic as single-cycle bonus events.

Parameters:
- DROP_THRESH, 6, drop occurs when lfsr[3:0] < DROP_THRESH (chance DROP_THRESH/16).
- LIFETIME_FRAMES, 300, frames a present stays solid after spawn.
- BLINK_FRAMES, 120, frames of blinking after lifetime expires, before removal.
- BLINK_PERIOD_LOG2, 3, visibility toggles every 2^BLINK_PERIOD_LOG2 frames while blinking.
- LFSR_SEED, 16'hACE1, non-zero reset seed.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- ball_pop  in  1  one-cycle pulse when a ball is split or destroyed
- pop_x  in  11  ball x position at pop
- col_player  in  3  player-present collision, bit i = slot i
- col_rope  in  3  rope-present collision, bit i = slot i
- slot_visible  out  3  draw enable per slot
- slot_reset  out  3  one-cycle spawn pulse per slot; object loads spawn_x
- spawn_x  out  11  spawn x, held valid while any slot_reset bit is high
- slot_type  out  6  2 bits per slot, slot i = [2i+1:2i]
- bonus_valid  out  1  one-cycle pulse per collected present
- bonus_type  out  2  type of the collected present, valid with bonus_valid
- drops_lost  out  8  saturating count of drops with no free slot

Behaviour:
- Reset: all slots FREE; all outputs 0; LFSR = LFSR_SEED; pending flags cleared.
- LFSR: 16-bit Galois, taps 0xB400, advances every clk.
- Drop decision: on ball_pop with lfsr[3:0] < DROP_THRESH, allocate the lowest-index FREE slot.
  - Allocated slot: type = lfsr[5:4]; spawn_x = pop_x clamped to 0..623.
  - slot_reset[i] asserts the next cycle, for exactly 1 cycle.
  - No free slot: drop is discarded and drops_lost increments, saturating at 255.
- Slot FSM per slot: FREE -> SPAWN -> LIVE -> BLINK -> FREE.
  - SPAWN: 1 cycle; slot_reset=1, visible=0.
  - LIVE: visible=1. The frame counter counts startOfFrame pulses; it goes to BLINK at LIFETIME_FRAMES.
  - BLINK: visible = ~frame_cnt[BLINK_PERIOD_LOG2]. Goes to FREE at BLINK_FRAMES.
  - LIVE or BLINK with col_player[i]: set pending[i], go to FREE; visible drops the next cycle.
  - LIVE or BLINK with col_rope[i] only: go to FREE with no bonus.
  - col_player and col_rope in the same cycle: player wins, bonus is granted.
  - Collisions in FREE and SPAWN are ignored.
- Bonus arbitration: each cycle, the lowest-index pending slot emits bonus_valid with its latched type, then clears.
  - Others wait; worst-case latency is 3 cycles.
  - A slot can be reallocated while its bonus is still pending; the latched type is kept separately from slot_type.
- Simultaneous ball_pop and slot release in the same cycle: the released slot is not yet FREE and is not allocated that cycle.
- slot_type holds its value after FREE until the next allocation.
- Reset mid-operation: immediate return to the reset state; pending bonuses are lost.

Optional Feature:
- Macro PRESENT_PITY_EN.
- Defined: a 3-bit counter counts ball_pop events that produced no drop.
  - When the count reaches 7, the next ball_pop forces a drop regardless of the LFSR.
  - The counter clears on any successful drop decision, even if the drop is lost for lack of a slot.
- Undefined: drops are purely LFSR-driven; the counter logic is absent.

Decomposition:
- Package present_pkg:
  - slot_state_t enum {FREE, SPAWN, LIVE, BLINK}
  - present_type_t logic [1:0]
  - NUM_SLOTS = 3
  - X_SPAWN_MAX = 623
- Sub-module present_slot_fsm, instantiated NUM_SLOTS times.
  - Contains: per-slot state, frame counter, visible/reset generation.
  - Allocation, LFSR, bonus arbitration and drops_lost stay in the top.

Test Plan:
- Force lfsr[3:0]=2, lfsr[5:4]=1; ball_pop with pop_x=700 -> next cycle slot_reset=3'b001, spawn_x=623, slot_type[1:0]=1; the cycle after, slot_visible=3'b001.
- All 3 slots LIVE; ball_pop with a passing LFSR -> no slot_reset pulse, drops_lost 0->1; repeat 300 times -> drops_lost=255.
- Slot 0 LIVE; 300 startOfFrame pulses -> BLINK, visible toggles every 8 frames; after 120 more frames -> slot_visible[0]=0 and no bonus.
- Slots 0 and 2 LIVE (types 3 and 1); col_player=3'b101 for one cycle -> bonus_valid on two consecutive cycles, bonus_type 3 then 1.
- Slot 1 LIVE; col_player[1]=1 and col_rope[1]=1 together -> bonus_valid=1 once; col_rope alone on another slot -> slot freed, no bonus.
- PRESENT_PITY_EN defined, DROP_THRESH=0: 7 ball_pops -> no spawn; 8th ball_pop -> slot_reset=3'b001.

Source files
------------

// File: rtl/present_pkg.sv
// Shared types and constants for the present drop scheduler and its slot FSMs.
package present_pkg;

   typedef enum logic [1:0] {FREE, SPAWN, LIVE, BLINK} slot_state_t;
   typedef logic [1:0] present_type_t;

   localparam int NUM_SLOTS   = 3;
   localparam int X_SPAWN_MAX = 623;

   function automatic logic [10:0] clamp_x(input logic [10:0] x);
      return (x > 11'(X_SPAWN_MAX)) ? 11'(X_SPAWN_MAX) : x;
   endfunction

endpackage

// File: rtl/present_slot_fsm.sv
// Lifetime tracker for one on-screen present slot: FREE -> SPAWN -> LIVE -> BLINK -> FREE.
module present_slot_fsm
   import present_pkg::*;
#(
   parameter int LIFETIME_FRAMES   = 300,
   parameter int BLINK_FRAMES      = 120,
   parameter int BLINK_PERIOD_LOG2 = 3
) (
   input  logic clk,
   input  logic resetN,
   input  logic alloc_i,
   input  logic sof_i,
   input  logic col_player_i,
   input  logic col_rope_i,
   output logic free_o,
   output logic visible_o,
   output logic reset_o,
   output logic collect_o
);

   localparam int CNT_MAX   = (LIFETIME_FRAMES > BLINK_FRAMES) ? LIFETIME_FRAMES : BLINK_FRAMES;
   localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
   localparam int CNT_W     = (CNT_W_RAW > BLINK_PERIOD_LOG2) ? CNT_W_RAW : BLINK_PERIOD_LOG2 + 1;

   slot_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             visible_q;
   logic             reset_q;
   logic             active;
   logic             hit;

   // Collisions only matter once the present is actually on screen.
   assign active    = (state_q == LIVE) || (state_q == BLINK);
   assign hit       = active && (col_player_i || col_rope_i);
   assign collect_o = active && col_player_i;
   assign free_o    = (state_q == FREE);
   assign visible_o = visible_q;
   assign reset_o   = reset_q;
   assign cnt_inc   = cnt_q + 1'b1;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= FREE;
         cnt_q     <= '0;
         visible_q <= 1'b0;
         reset_q   <= 1'b0;
      end else begin
         reset_q <= 1'b0;
         case (state_q)
            FREE: begin
               if (alloc_i) begin
                  state_q <= SPAWN;
                  reset_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            SPAWN: begin
               state_q   <= LIVE;
               visible_q <= 1'b1;
            end
            LIVE: begin
               if (hit) begin
                  state_q   <= FREE;
                  visible_q <= 1'b0;
               end else if (sof_i) begin
                  if (cnt_q == CNT_W'(LIFETIME_FRAMES - 1)) begin
                     state_q <= BLINK;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            BLINK: begin
               if (hit) begin
                  state_q   <= FREE;
                  visible_q <= 1'b0;
               end else if (sof_i) begin
                  if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                     state_q   <= FREE;
                     visible_q <= 1'b0;
                  end else begin
                     cnt_q     <= cnt_inc;
                     visible_q <= ~cnt_inc[BLINK_PERIOD_LOG2];
                  end
               end
            end
            default: state_q <= FREE;
         endcase
      end
   end

endmodule

// File: rtl/present_drop_scheduler.sv
// Present drop scheduler: LFSR drop decision, slot allocation, bonus arbitration.
// Optional PRESENT_PITY_EN forces a drop after 7 consecutive pops without one.
module present_drop_scheduler
   import present_pkg::*;
#(
   parameter int          DROP_THRESH       = 6,
   parameter int          LIFETIME_FRAMES   = 300,
   parameter int          BLINK_FRAMES      = 120,
   parameter int          BLINK_PERIOD_LOG2 = 3,
   parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic                   ball_pop,
   input  logic [10:0]            pop_x,
   input  logic [NUM_SLOTS-1:0]   col_player,
   input  logic [NUM_SLOTS-1:0]   col_rope,
   output logic [NUM_SLOTS-1:0]   slot_visible,
   output logic [NUM_SLOTS-1:0]   slot_reset,
   output logic [10:0]            spawn_x,
   output logic [2*NUM_SLOTS-1:0] slot_type,
   output logic                   bonus_valid,
   output logic [1:0]             bonus_type,
   output logic [7:0]             drops_lost
);

   logic [15:0]            lfsr_q;
   logic [15:0]            lfsr_d;
   logic [10:0]            spawn_x_q;
   logic [2*NUM_SLOTS-1:0] slot_type_q;
   logic [7:0]             drops_lost_q;
   logic [NUM_SLOTS-1:0]   pending_q;
   present_type_t          ptype_q [NUM_SLOTS];

   logic [NUM_SLOTS-1:0]   free;
   logic [NUM_SLOTS-1:0]   collect;
   logic [NUM_SLOTS-1:0]   alloc;
   logic [NUM_SLOTS-1:0]   grant;
   present_type_t          bonus_type_c;
   logic                   lfsr_pass;
   logic                   drop_req;

   assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign lfsr_pass = ({28'd0, lfsr_q[3:0]} < 32'(DROP_THRESH));

`ifdef PRESENT_PITY_EN
   logic [2:0] pity_q;

   assign drop_req = ball_pop && (lfsr_pass || (pity_q == 3'd7));

   // Any positive drop decision clears the streak, even if no slot was free.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pity_q <= 3'd0;
      end else if (ball_pop) begin
         pity_q <= drop_req ? 3'd0 : pity_q + 3'd1;
      end
   end
`else
   assign drop_req = ball_pop && lfsr_pass;
`endif

   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         present_slot_fsm #(
            .LIFETIME_FRAMES  (LIFETIME_FRAMES),
            .BLINK_FRAMES     (BLINK_FRAMES),
            .BLINK_PERIOD_LOG2(BLINK_PERIOD_LOG2)
         ) u_slot (
            .clk         (clk),
            .resetN      (resetN),
            .alloc_i     (alloc[gi]),
            .sof_i       (startOfFrame),
            .col_player_i(col_player[gi]),
            .col_rope_i  (col_rope[gi]),
            .free_o      (free[gi]),
            .visible_o   (slot_visible[gi]),
            .reset_o     (slot_reset[gi]),
            .collect_o   (collect[gi])
         );
      end
   endgenerate

   // Scanning downward lets the lowest-index candidate overwrite the rest.
   always_comb begin
      alloc        = '0;
      grant        = '0;
      bonus_type_c = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (drop_req && free[i]) begin
            alloc    = '0;
            alloc[i] = 1'b1;
         end
         if (pending_q[i]) begin
            grant        = '0;
            grant[i]     = 1'b1;
            bonus_type_c = ptype_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lfsr_q       <= LFSR_SEED;
         spawn_x_q    <= '0;
         slot_type_q  <= '0;
         drops_lost_q <= '0;
         pending_q    <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            ptype_q[i] <= '0;
         end
      end else begin
         lfsr_q <= lfsr_d;
         if (|alloc) begin
            spawn_x_q <= clamp_x(pop_x);
         end
         if (drop_req && (free == '0) && (drops_lost_q != 8'hFF)) begin
            drops_lost_q <= drops_lost_q + 8'd1;
         end
         // The bonus type is latched apart from slot_type so reallocation cannot corrupt it.
         pending_q <= (pending_q & ~grant) | collect;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (alloc[i]) begin
               slot_type_q[2*i +: 2] <= lfsr_q[5:4];
            end
            if (collect[i]) begin
               ptype_q[i] <= slot_type_q[2*i +: 2];
            end
         end
      end
   end

   assign spawn_x     = spawn_x_q;
   assign slot_type   = slot_type_q;
   assign drops_lost  = drops_lost_q;
   assign bonus_valid = |pending_q;
   assign bonus_type  = bonus_type_c;

endmodule

// File: tb/tb_present_drop_scheduler.sv
// Randomized scoreboard bench for present_drop_scheduler against a frame-count reference model.
module tb_present_drop_scheduler;

   localparam int LIFE   = 300;
   localparam int BLINKF = 120;
   localparam int THRESH = 6;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        ball_pop = 1'b0;
   logic [10:0] pop_x = '0;
   logic [2:0]  col_player = '0;
   logic [2:0]  col_rope = '0;
   logic [2:0]  slot_visible;
   logic [2:0]  slot_reset;
   logic [10:0] spawn_x;
   logic [5:0]  slot_type;
   logic        bonus_valid;
   logic [1:0]  bonus_type;
   logic [7:0]  drops_lost;

   always #5 clk = ~clk;

   present_drop_scheduler dut (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .ball_pop    (ball_pop),
      .pop_x       (pop_x),
      .col_player  (col_player),
      .col_rope    (col_rope),
      .slot_visible(slot_visible),
      .slot_reset  (slot_reset),
      .spawn_x     (spawn_x),
      .slot_type   (slot_type),
      .bonus_valid (bonus_valid),
      .bonus_type  (bonus_type),
      .drops_lost  (drops_lost)
   );

   typedef struct {int slot; int x;} spawn_t;
   typedef struct {int vis; int lost; int types;} cyc_t;

   spawn_t spawn_q[$];
   int     bonus_q[$];
   cyc_t   cyc_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   // Reference model: each slot is described by whether it is occupied,
   // whether it was allocated on the previous edge, and total frames lived.
   int m_busy[3], m_new[3], m_frames[3], m_type[3], m_pend[3], m_ptype[3];
   int m_lfsr, m_lost, m_pity;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0; m_new[i] = 0; m_frames[i] = 0;
         m_type[i] = 0; m_pend[i] = 0; m_ptype[i] = 0;
      end
      m_lfsr = 'hACE1;
      m_lost = 0;
      m_pity = 0;
   endtask

   task automatic model_step(input int pop, input int x, input int cp, input int cr, input int sof);
      int     win;
      int     free_pre[3];
      int     pass;
      int     slot;
      int     vis;
      int     types;
      cyc_t   c;
      spawn_t s;
      win = -1;
      for (int i = 0; i < 3; i++) if (m_pend[i] != 0 && win < 0) win = i;
      if (win >= 0) m_pend[win] = 0;
      for (int i = 0; i < 3; i++) free_pre[i] = (m_busy[i] == 0) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         if (m_busy[i] != 0 && m_new[i] == 0) begin
            if (((cp >> i) & 1) != 0 || ((cr >> i) & 1) != 0) begin
               if (((cp >> i) & 1) != 0) begin
                  m_pend[i]  = 1;
                  m_ptype[i] = m_type[i];
               end
               m_busy[i] = 0;
            end else if (sof != 0) begin
               m_frames[i]++;
               if (m_frames[i] == LIFE + BLINKF) m_busy[i] = 0;
            end
         end else if (m_busy[i] != 0) begin
            m_new[i]    = 0;
            m_frames[i] = 0;
         end
      end
      pass = (pop != 0 && (m_lfsr & 15) < THRESH) ? 1 : 0;
`ifdef PRESENT_PITY_EN
      if (pop != 0 && m_pity == 7) pass = 1;
      if (pop != 0) m_pity = (pass != 0) ? 0 : m_pity + 1;
`endif
      if (pass != 0) begin
         slot = -1;
         for (int i = 0; i < 3; i++) if (free_pre[i] != 0 && slot < 0) slot = i;
         if (slot >= 0) begin
            m_busy[slot]   = 1;
            m_new[slot]    = 1;
            m_frames[slot] = 0;
            m_type[slot]   = (m_lfsr >> 4) & 3;
            s.slot = slot;
            s.x    = (x > 623) ? 623 : x;
            spawn_q.push_back(s);
         end else if (m_lost < 255) begin
            m_lost++;
         end
      end
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
      vis   = 0;
      types = 0;
      for (int i = 0; i < 3; i++) begin
         if (m_busy[i] != 0 && m_new[i] == 0) begin
            if (m_frames[i] < LIFE) vis |= (1 << i);
            else if ((((m_frames[i] - LIFE) >> 3) & 1) == 0) vis |= (1 << i);
         end
         types |= (m_type[i] << (2 * i));
      end
      c.vis   = vis;
      c.lost  = m_lost;
      c.types = types;
      cyc_q.push_back(c);
      win = -1;
      for (int i = 0; i < 3; i++) if (m_pend[i] != 0 && win < 0) win = i;
      if (win >= 0) bonus_q.push_back(m_ptype[win]);
   endtask

   // Drive one cycle of random stimulus (probabilities in percent) and advance the model.
   task automatic apply_step(input int pp, input int sp, input int cpp, input int crp);
      int pop, x, cp, cr, sof;
      pop = ($urandom_range(0, 99) < pp) ? 1 : 0;
      sof = ($urandom_range(0, 99) < sp) ? 1 : 0;
      cp  = 0;
      cr  = 0;
      for (int i = 0; i < 3; i++) begin
         if ($urandom_range(0, 99) < cpp) cp |= (1 << i);
         if ($urandom_range(0, 99) < crp) cr |= (1 << i);
      end
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(621, 626));
      else x = int'($urandom_range(0, 2047));
      ball_pop     = (pop != 0);
      startOfFrame = (sof != 0);
      pop_x        = 11'(x);
      col_player   = 3'(cp);
      col_rope     = 3'(cr);
      model_step(pop, x, cp, cr, sof);
   endtask

   task automatic run_phase(input int n, input int pp, input int sp, input int cpp, input int crp);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         apply_step(pp, sp, cpp, crp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_slot_visible"}, int'(slot_visible), 0);
      chk({tag, "_slot_reset"}, int'(slot_reset), 0);
      chk({tag, "_spawn_x"}, int'(spawn_x), 0);
      chk({tag, "_slot_type"}, int'(slot_type), 0);
      chk({tag, "_bonus_valid"}, int'(bonus_valid), 0);
      chk({tag, "_bonus_type"}, int'(bonus_type), 0);
      chk({tag, "_drops_lost"}, int'(drops_lost), 0);
   endtask

   // Monitor: compares whatever the DUT presents just after each active edge.
   initial begin
      cyc_t   c;
      spawn_t s;
      int     b;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (cyc_q.size() > 0) begin
               c = cyc_q.pop_front();
               chk("slot_visible", int'(slot_visible), c.vis);
               chk("drops_lost", int'(drops_lost), c.lost);
               chk("slot_type", int'(slot_type), c.types);
            end
            if (slot_reset != '0) begin
               if (spawn_q.size() == 0) begin
                  chk("spawn_unexpected", int'(slot_reset), 0);
               end else begin
                  s = spawn_q.pop_front();
                  chk("slot_reset", int'(slot_reset), 1 << s.slot);
                  chk("spawn_x", int'(spawn_x), s.x);
                  $display("spawn slot=%0d x=%0d type=%0d", s.slot, s.x, (c.types >> (2 * s.slot)) & 3);
               end
            end
            if (bonus_valid) begin
               if (bonus_q.size() == 0) begin
                  chk("bonus_unexpected", int'(bonus_valid), 0);
               end else begin
                  b = bonus_q.pop_front();
                  chk("bonus_type", int'(bonus_type), b);
                  $display("bonus type=%0d", b);
               end
            end
         end
      end
   end

   initial begin
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      model_reset();
      resetN = 1'b1;
      mon_en = 1'b1;
      apply_step(30, 50, 4, 4);

      run_phase(2500, 30, 50, 4, 4);   // mixed traffic
      run_phase(3000, 50, 25, 0, 0);   // slots saturated: drops_lost climbs to 255
      run_phase(1000, 10, 100, 0, 0);  // lifetimes expire through blinking
      run_phase(800, 50, 50, 25, 15);  // heavy collisions: bonus arbitration

      // Asynchronous reset mid-operation, possibly with bonuses still pending.
      @(negedge clk);
      mon_en       = 1'b0;
      resetN       = 1'b0;
      ball_pop     = 1'b0;
      startOfFrame = 1'b0;
      col_player   = '0;
      col_rope     = '0;
      #1;
      check_reset_outputs("midrst");
      spawn_q.delete();
      bonus_q.delete();
      cyc_q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      mon_en = 1'b1;
      apply_step(50, 50, 10, 10);
      run_phase(300, 50, 50, 10, 10);
      run_phase(6, 0, 0, 0, 0);

      @(posedge clk);
      #2;
      chk("spawn_q_left", spawn_q.size(), 0);
      chk("bonus_q_left", bonus_q.size(), 0);
      chk("cyc_q_left", cyc_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
